// File: rtl/reg_sched_pkg.sv
// Shared widths and the pick-result type for the register-file write scheduler.
package reg_sched_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DWIDTH = 8;
  localparam int DEF_AWIDTH = 3;
  // Requester ids are sized for the largest supported NREQ (8).
  localparam int IDW        = 3;
  localparam int CNTW       = 16;

  typedef struct packed {
    logic           g0_vld;
    logic [IDW-1:0] g0_id;
    logic           g1_vld;
    logic [IDW-1:0] g1_id;
    logic           s_vld;
    logic [IDW-1:0] s_id;
  } pick_t;

endpackage

// File: rtl/reg_wr_sched_rr_pick.sv
// Combinational round-robin scan from pointer p: first valid -> g0, next valid
// with a different target index -> g1, first same-index requester seen before g1 -> s.
module rr_pick
  import reg_sched_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int PW     = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0]        valid,
  input  logic [NREQ*AWIDTH-1:0] index,
  input  logic [PW-1:0]          p,
  output pick_t                  pick
);

  int               i;
  logic [AWIDTH-1:0] a_idx;

  always_comb begin
    pick  = '0;
    a_idx = '0;
    i     = 0;
    for (int k = 0; k < NREQ; k++) begin
      i = (int'(p) + k) % NREQ;
      // The scan effectively ends at g1, so later conflicts never move the pointer.
      if (valid[i] && !pick.g1_vld) begin
        if (!pick.g0_vld) begin
          pick.g0_vld = 1'b1;
          pick.g0_id  = IDW'(i);
          a_idx       = index[i*AWIDTH +: AWIDTH];
        end else if (index[i*AWIDTH +: AWIDTH] == a_idx) begin
          if (!pick.s_vld) begin
            pick.s_vld = 1'b1;
            pick.s_id  = IDW'(i);
          end
        end else begin
          pick.g1_vld = 1'b1;
          pick.g1_id  = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/reg_wr_sched.sv
// Packs up to two non-conflicting writes per cycle onto register-file ports A/B,
// forwarding read indices on idle cycles. Optional stats via REG_WR_SCHED_STATS_EN.
module reg_wr_sched
  import reg_sched_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AWIDTH-1:0] req_index,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   hold,
  input  logic [AWIDTH-1:0]      rd_a_index,
  input  logic [AWIDTH-1:0]      rd_b_index,
  output logic                   rf_wen,
  output logic [AWIDTH-1:0]      rf_aindex,
  output logic [AWIDTH-1:0]      rf_bindex,
  output logic [DWIDTH-1:0]      rf_ain,
  output logic [DWIDTH-1:0]      rf_bin,
  output logic                   rd_ok,
  output logic                   busy
`ifdef REG_WR_SCHED_STATS_EN
  ,output logic [NREQ*CNTW-1:0]  stat_grants
  ,output logic [CNTW-1:0]       stat_conflicts
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]  p;
  pick_t          pick;
  logic           grant;
  logic [IDW-1:0] last;
  logic [IDW:0]   nxt;
  logic [PW-1:0]  p_next;

  rr_pick #(.NREQ(NREQ), .AWIDTH(AWIDTH), .PW(PW)) u_pick (
    .valid (req_valid),
    .index (req_index),
    .p     (p),
    .pick  (pick)
  );

  assign grant  = pick.g0_vld & ~hold & ~rst;
  assign last   = pick.g1_vld ? pick.g1_id : pick.g0_id;
  assign nxt    = {1'b0, last} + (IDW+1)'(1);
  // A skipped same-index requester goes first next cycle.
  assign p_next = pick.s_vld ? PW'(pick.s_id)
                : (nxt == (IDW+1)'(NREQ)) ? '0 : PW'(nxt);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rdy
    assign req_ready[gi] = ~rst & ~hold &
                           ((pick.g0_vld & (pick.g0_id == IDW'(gi))) |
                            (pick.g1_vld & (pick.g1_id == IDW'(gi))));
  end

  assign busy = (|req_valid) | rf_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= '0;
      rf_wen    <= 1'b0;
      rf_aindex <= '0;
      rf_bindex <= '0;
      rf_ain    <= '0;
      rf_bin    <= '0;
      rd_ok     <= 1'b0;
    end else if (grant) begin
      p         <= p_next;
      rf_wen    <= 1'b1;
      rd_ok     <= 1'b0;
      rf_aindex <= req_index[pick.g0_id*AWIDTH +: AWIDTH];
      rf_ain    <= req_data[pick.g0_id*DWIDTH +: DWIDTH];
      // B must mirror A on single grants: its decoder is live whenever wen is.
      if (pick.g1_vld) begin
        rf_bindex <= req_index[pick.g1_id*AWIDTH +: AWIDTH];
        rf_bin    <= req_data[pick.g1_id*DWIDTH +: DWIDTH];
      end else begin
        rf_bindex <= req_index[pick.g0_id*AWIDTH +: AWIDTH];
        rf_bin    <= req_data[pick.g0_id*DWIDTH +: DWIDTH];
      end
    end else begin
      rf_wen    <= 1'b0;
      rd_ok     <= 1'b1;
      rf_aindex <= rd_a_index;
      rf_bindex <= rd_b_index;
    end
  end

`ifdef REG_WR_SCHED_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst)
        stat_grants[gi*CNTW +: CNTW] <= '0;
      else if (req_valid[gi] && req_ready[gi] && !(&stat_grants[gi*CNTW +: CNTW]))
        stat_grants[gi*CNTW +: CNTW] <= stat_grants[gi*CNTW +: CNTW] + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stat_conflicts <= '0;
    else if (grant && pick.s_vld && !(&stat_conflicts))
      stat_conflicts <= stat_conflicts + CNTW'(1);
  end
`endif

endmodule

// File: tb/tb_reg_wr_sched.sv
// Directed scoreboard bench: each stimulus cycle queues the rf_* state expected
// on the following cycle; a negedge monitor pops whenever rf_wen or rd_ok is high.
module tb_reg_wr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] ai;
    logic [AW-1:0] bi;
    logic [DW-1:0] ad;
    logic [DW-1:0] bd;
    logic          rdok;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '1;
  logic [NREQ*AW-1:0]   req_index = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 hold = 1'b0;
  logic [AW-1:0]        rd_a_index = '0;
  logic [AW-1:0]        rd_b_index = '0;
  logic                 rf_wen;
  logic [AW-1:0]        rf_aindex, rf_bindex;
  logic [DW-1:0]        rf_ain, rf_bin;
  logic                 rd_ok;
  logic                 busy;
`ifdef REG_WR_SCHED_STATS_EN
  logic [NREQ*16-1:0]   stat_grants;
  logic [15:0]          stat_conflicts;
`endif

  logic [AW-1:0] idx [NREQ];
  logic [DW-1:0] dat [NREQ];
  exp_t          q[$];
  int            vectors = 0;
  int            errors  = 0;
  logic          mon_en  = 1'b1;

  always #5 clk = ~clk;

  reg_wr_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_data(req_data), .req_ready(req_ready), .hold(hold),
    .rd_a_index(rd_a_index), .rd_b_index(rd_b_index), .rf_wen(rf_wen),
    .rf_aindex(rf_aindex), .rf_bindex(rf_bindex), .rf_ain(rf_ain),
    .rf_bin(rf_bin), .rd_ok(rd_ok), .busy(busy)
`ifdef REG_WR_SCHED_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive, check the combinational grant, queue next-cycle rf state.
  task automatic step(input logic [3:0] v, input logic h, input logic r,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [3:0] exp_rdy, input logic push, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; hold = h; req_valid = v; rd_a_index = ra; rd_b_index = rb;
    for (int j = 0; j < NREQ; j++) begin
      req_index[j*AW +: AW] = idx[j];
      req_data[j*DW +: DW]  = dat[j];
    end
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (push) q.push_back(e);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {rf_wen, rf_aindex, rf_bindex, rf_ain, rf_bin, rd_ok}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && (rf_wen === 1'b1 || rd_ok === 1'b1)) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rf_out: unexpected output wen=%b a=%0d b=%0d, expected none queued",
                 rf_wen, rf_aindex, rf_bindex);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rf_out", 32'({rf_wen, rf_aindex, rf_bindex, rf_ain, rf_bin, rd_ok}), 32'(e));
      end
    end
  end

  initial begin
    idx[0] = 3'd1; idx[1] = 3'd2; idx[2] = 3'd3; idx[3] = 3'd4;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;

    // Reset held two cycles with every requester valid.
    step(4'b1111, 0, 1, 0, 0, 4'b0000, 0, '0);
    step(4'b1111, 0, 1, 0, 0, 4'b0000, 0, '0);
    step(4'b1111, 0, 0, 0, 0, 4'b0011, 1, '{1, 3'd1, 3'd2, 8'h11, 8'h22, 0});
    chk_zero("reset_rf");
    step(4'b1100, 0, 0, 0, 0, 4'b1100, 1, '{1, 3'd3, 3'd4, 8'h33, 8'h44, 0});
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 1, '{0, 3'd0, 3'd0, 8'h33, 8'h44, 1});

    // Index conflict: req1 is skipped, then served alone on both ports.
    idx[0] = 3'd5; idx[1] = 3'd5; idx[2] = 3'd6;
    dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'hCC;
    step(4'b0111, 0, 0, 0, 0, 4'b0101, 1, '{1, 3'd5, 3'd6, 8'hAA, 8'hCC, 0});
    step(4'b0010, 0, 0, 0, 0, 4'b0010, 1, '{1, 3'd5, 3'd5, 8'hBB, 8'hBB, 0});

    // Single requester, then hold with the read path active, then release.
    idx[3] = 3'd7; dat[3] = 8'h5A;
    step(4'b1000, 0, 0, 0, 0, 4'b1000, 1, '{1, 3'd7, 3'd7, 8'h5A, 8'h5A, 0});
    step(4'b1000, 1, 0, 3'd3, 3'd6, 4'b0000, 1, '{0, 3'd3, 3'd6, 8'h5A, 8'h5A, 1});
    step(4'b1000, 0, 0, 3'd3, 3'd6, 4'b1000, 1, '{1, 3'd7, 3'd7, 8'h5A, 8'h5A, 0});
    step(4'b0000, 0, 0, 3'd1, 3'd2, 4'b0000, 1, '{0, 3'd1, 3'd2, 8'h5A, 8'h5A, 1});

    // Grant just before a reset: visible in the rst cycle, then dropped; p restarts at 0.
    idx[0] = 3'd4; dat[0] = 8'h77;
    step(4'b0001, 0, 0, 0, 0, 4'b0001, 1, '{1, 3'd4, 3'd4, 8'h77, 8'h77, 0});
    idx[0] = 3'd1; idx[1] = 3'd2; idx[2] = 3'd3; idx[3] = 3'd4;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    step(4'b1111, 0, 1, 0, 0, 4'b0000, 0, '0);
    step(4'b1111, 0, 0, 0, 0, 4'b0011, 1, '{1, 3'd1, 3'd2, 8'h11, 8'h22, 0});
    chk_zero("midrst_rf");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 1, '{0, 3'd0, 3'd0, 8'h11, 8'h22, 1});

    @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef REG_WR_SCHED_STATS_EN
    chk("stat_conflicts", 32'(stat_conflicts), 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
